// File: rtl/sram_pixel_arbiter_if.sv
// Client request/ack bus of sram_pixel_arbiter: the walker side drives the request fields,
// the arbiter returns the acknowledge and registered read data.
interface sram_pixel_arbiter_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
);
  logic              iReq;
  logic              iWe;
  logic [ADDR_W-1:0] iAddr;
  logic [DATA_W-1:0] iWData;
  logic              oAck;
  logic              oRValid;
  logic [DATA_W-1:0] oRData;

  modport master (
    output iReq, iWe, iAddr, iWData,
    input  oAck, oRValid, oRData
  );

  modport slave (
    input  iReq, iWe, iAddr, iWData,
    output oAck, oRValid, oRData
  );
endinterface

// File: rtl/sram_pixel_arbiter.sv
// Time-multiplexes one async SRAM between VGA scan-out (even phases) and a req/ack client.
// Optional macro ARB_STALL_CNT_EN adds the oStall_Cnt client stall counter output.
module sram_pixel_arbiter #(
  parameter int unsigned X_W    = 10,
  parameter int unsigned Y_W    = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iScan_En,
  input  logic [X_W-1:0]       iScan_X,
  input  logic [Y_W-1:0]       iScan_Y,
  output logic [DATA_W-1:0]    oScan_Data,
  sram_pixel_arbiter_if.slave  cl,
  output logic [X_W+Y_W-1:0]   oSRAM_ADDR,
  inout  wire  [DATA_W-1:0]    SRAM_DQ,
  output logic                 oSRAM_WE_N,
  output logic                 oSRAM_OE_N,
  output logic                 oSRAM_CE_N,
  output logic                 oSRAM_UB_N,
  output logic                 oSRAM_LB_N
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [15:0]          oStall_Cnt
`endif
);

  typedef enum logic [1:0] {
    AccIdle,
    AccScanRd,
    AccClRd,
    AccClWr
  } acc_e;

  acc_e                 w_acc;
  logic                 w_issue_cl;

  logic                 r_phase;
  logic                 r_pend_scan;
  logic                 r_pend_cl;
  logic                 r_ack;
  logic                 r_rvalid;
  logic [DATA_W-1:0]    r_rdata;
  logic [DATA_W-1:0]    r_scan_data;
  logic [X_W+Y_W-1:0]   r_addr;
  logic                 r_we_n;
  logic                 r_oe_n;
  logic                 r_dq_oe;
  logic [DATA_W-1:0]    r_wdata;

  // Scan wins the phase-0 slot during active video; otherwise the client gets the slot.
  always_comb begin
    w_acc = AccIdle;
    if (!r_phase && iScan_En) begin
      w_acc = AccScanRd;
    end else if (cl.iReq) begin
      w_acc = cl.iWe ? AccClWr : AccClRd;
    end
  end

  assign w_issue_cl = (w_acc == AccClRd) || (w_acc == AccClWr);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_phase     <= 1'b0;
      r_pend_scan <= 1'b0;
      r_pend_cl   <= 1'b0;
      r_ack       <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_scan_data <= '0;
      r_addr      <= '0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_wdata     <= '0;
    end else begin
      r_phase     <= ~r_phase;
      r_pend_scan <= (w_acc == AccScanRd);
      r_pend_cl   <= (w_acc == AccClRd);
      r_ack       <= w_issue_cl;
      r_rvalid    <= r_pend_cl;
      // Captures sample the address driven during the cycle that just ended.
      if (r_pend_scan) r_scan_data <= SRAM_DQ;
      if (r_pend_cl)   r_rdata     <= SRAM_DQ;
      r_we_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_dq_oe <= 1'b0;
      unique case (w_acc)
        AccScanRd: begin
          r_addr <= {iScan_X, iScan_Y};
          r_oe_n <= 1'b0;
        end
        AccClRd: begin
          r_addr <= cl.iAddr;
          r_oe_n <= 1'b0;
        end
        AccClWr: begin
          r_addr  <= cl.iAddr;
          r_we_n  <= 1'b0;
          r_dq_oe <= 1'b1;
          r_wdata <= cl.iWData;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_stall_cnt <= '0;
    end else if (!cl.iReq) begin
      r_stall_cnt <= '0;
    end else if (!w_issue_cl && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign oStall_Cnt = r_stall_cnt;
`endif

  assign SRAM_DQ     = r_dq_oe ? r_wdata : {DATA_W{1'bz}};
  assign oSRAM_ADDR  = r_addr;
  assign oSRAM_WE_N  = r_we_n;
  assign oSRAM_OE_N  = r_oe_n;
  assign oSRAM_CE_N  = 1'b0;
  assign oSRAM_UB_N  = 1'b0;
  assign oSRAM_LB_N  = 1'b0;
  assign oScan_Data  = r_scan_data;
  assign cl.oAck     = r_ack;
  assign cl.oRValid  = r_rvalid;
  assign cl.oRData   = r_rdata;

endmodule

// File: tb/tb_sram_pixel_arbiter.sv
// Scoreboard bench for sram_pixel_arbiter: SRAM pin model, reference memory, random client traffic.
module tb_sram_pixel_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en;
  logic [9:0]  scan_x;
  logic [9:0]  scan_y;
  logic [15:0] scan_data;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;
`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  sram_pixel_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();

  sram_pixel_arbiter #(.X_W(10), .Y_W(10), .DATA_W(16)) dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .iScan_En   (scan_en),
    .iScan_X    (scan_x),
    .iScan_Y    (scan_y),
    .oScan_Data (scan_data),
    .cl         (bus),
    .oSRAM_ADDR (sram_addr),
    .SRAM_DQ    (sram_dq),
    .oSRAM_WE_N (we_n),
    .oSRAM_OE_N (oe_n),
    .oSRAM_CE_N (ce_n),
    .oSRAM_UB_N (ub_n),
    .oSRAM_LB_N (lb_n)
`ifdef ARB_STALL_CNT_EN
    ,
    .oStall_Cnt (stall_cnt)
`endif
  );

  // Async SRAM pin model and the bench's own reference memory.
  logic [15:0] mem     [0:1048575];
  logic [15:0] ref_mem [0:1048575];

  assign sram_dq = (!oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (!we_n) mem[sram_addr] <= sram_dq;
  end

  function automatic logic [15:0] init_val(input logic [19:0] a);
    return a[15:0] ^ {a[19:16], 12'hA53};
  endfunction

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_low_cnt = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read-data monitor: every oRValid must match the oldest outstanding expected read.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!we_n) we_low_cnt++;
    if (bus.oRValid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: got oRValid=1 with data 0x%0h, required no read pending",
                 bus.oRData);
      end else begin
        check("rdata", {16'h0, bus.oRData}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // Presents one request and waits for its ack; returns edges waited and ack cycle.
  task automatic client_op(input bit we, input logic [19:0] a, input logic [15:0] d,
                           output int n_edges, output int ack_cyc);
    bus.iReq   = 1'b1;
    bus.iWe    = we;
    bus.iAddr  = a;
    bus.iWData = d;
    if (we) ref_mem[a] = d;
    else    exp_q.push_back(ref_mem[a]);
    ack_cyc = -1;
    n_edges = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_edges++;
      if (bus.oAck) begin
        ack_cyc = cyc;
        break;
      end
    end
    check("ack_seen", {31'h0, ack_cyc >= 0}, 32'h1);
    bus.iReq = 1'b0;
  endtask

  initial begin
    int n, c, c_prev, w0;
    logic [19:0] a;

    for (int i = 0; i < 1048576; i++) begin
      mem[i]     = init_val(20'(i));
      ref_mem[i] = init_val(20'(i));
    end
    mem[{10'd80, 10'd200}]     = 16'hFFFF;
    ref_mem[{10'd80, 10'd200}] = 16'hFFFF;

    // Reset with scan enabled and a read already requested.
    scan_en = 1'b1;
    scan_x = 10'd80;
    scan_y = 10'd200;
    bus.iReq = 1'b1;
    bus.iWe = 1'b0;
    bus.iAddr = {10'd5, 10'd7};
    bus.iWData = 16'h0;
    exp_q.push_back(ref_mem[{10'd5, 10'd7}]);
    repeat (3) begin
      @(negedge clk);
      check("rst_we_n", {31'h0, we_n}, 32'h1);
      check("rst_oe_n", {31'h0, oe_n}, 32'h1);
      check("rst_ack", {31'h0, bus.oAck}, 32'h0);
      check("rst_scan_data", {16'h0, scan_data}, 32'h0);
      check("rst_addr", {12'h0, sram_addr}, 32'h0);
`ifdef ARB_STALL_CNT_EN
      check("rst_stall", {16'h0, stall_cnt}, 32'h0);
`endif
    end
    check("ce_ub_lb", {29'h0, ce_n, ub_n, lb_n}, 32'h0);
    rst_n = 1'b1;

    @(posedge clk); #1;
    check("scan_addr", {12'h0, sram_addr}, 32'h140C8);
    check("scan_oe_n", {31'h0, oe_n}, 32'h0);
    check("scan_no_ack", {31'h0, bus.oAck}, 32'h0);
`ifdef ARB_STALL_CNT_EN
    check("stall_one", {16'h0, stall_cnt}, 32'h1);
`endif
    @(posedge clk); #1;
    check("cl_ack", {31'h0, bus.oAck}, 32'h1);
    check("cl_addr", {12'h0, sram_addr}, {12'h0, 10'd5, 10'd7});
    check("scan_pixel", {16'h0, scan_data}, 32'hFFFF);
`ifdef ARB_STALL_CNT_EN
    check("stall_hold", {16'h0, stall_cnt}, 32'h1);
`endif
    bus.iReq = 1'b0;
    scan_en = 1'b0;
    @(posedge clk); #1;
    check("cl_rvalid", {31'h0, bus.oRValid}, 32'h1);

    // Write then read back-to-back with scan idle.
    w0 = we_low_cnt;
    client_op(1'b1, {10'd3, 10'd4}, 16'h1234, n, c_prev);
    check("wr_lat", n, 1);
    client_op(1'b0, {10'd3, 10'd4}, 16'h0, n, c);
    check("wr_rd_consecutive", c, c_prev + 1);
    repeat (2) @(posedge clk);
    #2;
    check("we_low_cycles", we_low_cnt - w0, 1);
    check("rdata_1234", {16'h0, bus.oRData}, 32'h1234);

    // Four back-to-back reads.
    c_prev = -1;
    for (int i = 0; i < 4; i++) begin
      a = 20'h00100 + 20'($urandom_range(0, 15));
      client_op(1'b0, a, 16'h0, n, c);
      if (i > 0) check("rd4_consecutive", c, c_prev + 1);
      c_prev = c;
    end
    repeat (2) @(posedge clk);
    #1;

    // Scan fetches at assorted coordinates.
    scan_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 20'h80000 + 20'($urandom_range(0, 65535));
      {scan_x, scan_y} = a;
      repeat (4) @(posedge clk);
      #1;
      check("scan_fetch", {16'h0, scan_data}, {16'h0, ref_mem[a]});
    end
    scan_x = 10'd80;
    scan_y = 10'd200;

    // Random client traffic with scan enable toggling between requests.
    for (int i = 0; i < 150; i++) begin
      scan_en = 1'($urandom_range(0, 1));
      a = 20'h00100 + 20'($urandom_range(0, 15));
      client_op(1'($urandom_range(0, 1)), a, 16'($urandom), n, c);
      if (scan_en) check("ack_lat_scan", {31'h0, n <= 2}, 32'h1);
      else         check("ack_lat_idle", n, 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    scan_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("scan_after_traffic", {16'h0, scan_data}, 32'hFFFF);
    scan_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset right after a read is acked: the read must vanish.
    client_op(1'b0, {10'd5, 10'd7}, 16'h0, n, c);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      check("rst_mid_rvalid", {31'h0, bus.oRValid}, 32'h0);
      check("rst_mid_rdata", {16'h0, bus.oRData}, 32'h0);
      check("rst_mid_we_n", {31'h0, we_n}, 32'h1);
      check("rst_mid_oe_n", {31'h0, oe_n}, 32'h1);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_rdata", {16'h0, bus.oRData}, 32'h0);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_pixel_arbiter.md
Name: sram_pixel_arbiter

Overview:
- Sits between the SRAM pins and two masters: the VGA scan-out path (pixel fetch at the VGA_Controller coordinates) and the walker/drawing FSM.
- Time-multiplexes the single-port async SRAM and returns scan pixels as registered data to VGA_Controller's iRed/iGreen/iBlue path.
- Gives the walker a req/ack read/write port with a fixed read latency.
- Replaces the ad-hoc shared addr_reg/write_enable SRAM driving in the top level.

Parameters:
- X_W, 10, width of scan X coordinate.
- Y_W, 10, width of scan Y coordinate; SRAM address = {X, Y}, width X_W+Y_W.
- DATA_W, 16, SRAM data width.

Ports:
- iCLK  input  1  VGA_CTL_CLK domain clock.
- iRST_N  input  1  asynchronous active-low reset.
- iScan_En  input  1  high while the scan is inside the active display area.
- iScan_X  input  X_W  scan pixel X (VGA_Controller oCoord_X).
- iScan_Y  input  Y_W  scan pixel Y (VGA_Controller oCoord_Y).
- oScan_Data  output  DATA_W  last fetched scan pixel, registered.
- iReq  input  1  client request; held with its fields until oAck.
- iWe  input  1  client op: 1 = write, 0 = read.
- iAddr  input  X_W+Y_W  client address {x, y}.
- iWData  input  DATA_W  client write data.
- oAck  output  1  one-cycle pulse: request issued to SRAM this edge.
- oRValid  output  1  one-cycle pulse: oRData valid.
- oRData  output  DATA_W  client read data, held until the next oRValid.
- oSRAM_ADDR  output  X_W+Y_W  SRAM address, registered.
- SRAM_DQ  inout  DATA_W  driven only during a write cycle, else high-Z.
- oSRAM_WE_N, oSRAM_OE_N  output  1 each  registered strobes.
- oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N  output  1 each  constant 0.

Behaviour:
- Reset (async, iRST_N low), all outputs immediate:
  - phase=0; oSRAM_ADDR=0; oSRAM_WE_N=1; oSRAM_OE_N=1; DQ high-Z.
  - oScan_Data=0; oAck=0; oRValid=0; oRData=0; internal pend_scan=0, pend_cl=0.
- Phase bit toggles every cycle. Each edge issues at most one SRAM access:
  - SCAN_RD when phase=0 and iScan_En=1.
  - Otherwise CL_RD or CL_WR if iReq=1.
  - Otherwise IDLE.
- Scan therefore owns every even cycle during active video. Clients get every odd cycle, plus all cycles while iScan_En=0.
- SCAN_RD edge:
  - oSRAM_ADDR<={iScan_X,iScan_Y}; OE_N<=0; WE_N<=1; pend_scan<=1.
  - Next edge: oScan_Data<=SRAM_DQ; pend_scan<=0.
  - oScan_Data holds between fetches, so each fetched pixel is displayed for 2 cycles.
- CL_RD edge:
  - oSRAM_ADDR<=iAddr; OE_N<=0; WE_N<=1; oAck<=1; pend_cl<=1.
  - Next edge: oRData<=SRAM_DQ; oRValid<=1.
  - Read latency = 1 cycle after oAck.
- CL_WR edge:
  - oSRAM_ADDR<=iAddr; WE_N<=0; OE_N<=1; DQ driven with iWData for exactly that cycle; oAck<=1; no oRValid.
- IDLE edge: WE_N<=1; OE_N<=1; DQ high-Z; address holds.
- Handshake:
  - Client keeps iReq and its fields stable until it sees oAck.
  - oAck fires exactly once per request. The client may drop iReq or present a new request in the cycle oAck is high.
  - Back-to-back client ops are legal: max one per cycle when iScan_En=0, one per 2 cycles when iScan_En=1.
- Capture and issue may coincide: a capture of the previous read and the issue of the next access on the same edge are legal. Data is sampled from the previous cycle's address.
- Write→read turnaround: DQ is released on the edge that ends the write, so a following read samples one full cycle later. No contention.
- iScan_En falling mid-line: the phase-0 slot goes to the client on that same edge. A pending scan capture still completes.
- iScan_En rising: scan takes the next phase-0 edge. Phase is never resynchronised to coordinates.
- Reset mid-operation: any in-flight read is dropped. No oRValid follows reset, and an un-acked request must be re-presented.

Optional Feature:
- Macro ARB_STALL_CNT_EN.
- Defined:
  - Extra output oStall_Cnt [15:0].
  - Increments each cycle iReq=1 and oAck is not issued that edge; saturates at 16'hFFFF.
  - Clears to 0 when iReq=0; reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset with iScan_En=1, iReq=1 held low-reset 3 cycles → WE_N=1, OE_N=1, DQ=Z, oAck=0, oScan_Data=0 throughout; first SCAN_RD on first phase-0 edge after release.
- SRAM model preloaded addr {10'd80,10'd200}=16'hFFFF; iScan_En=1, X=80, Y=200 → oSRAM_ADDR=0x14 0C8 on scan edge, oScan_Data=16'hFFFF one edge later.
- iScan_En=1, client read iAddr={10'd5,10'd7} asserted on a phase-0 edge → oAck on the following (phase-1) edge, oRValid with preloaded data one edge after that; stall count 1 when ARB_STALL_CNT_EN.
- iScan_En=0, client write 16'h1234 to {10'd3,10'd4} then read same address back-to-back → oAck on two consecutive edges, WE_N low exactly one cycle, oRData=16'h1234.
- iScan_En=0, four consecutive client reads → four oAck pulses on four consecutive edges, four oRValid each 1 cycle later, in order.
- Assert iRST_N low the cycle after a CL_RD oAck → no oRValid, oRData=0, DQ high-Z.
